// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: o_div_clk = i_clk / N, divisor swapped only at period wrap.
// Optional CLK_DIV_ODD_DUTY_EN adds a negedge stage giving 50% duty for odd N.
module clk_div_ctrl #(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_cfg_valid,
    input  logic [CNT_WIDTH-1:0] i_cfg_div,
    output logic                 o_cfg_ready,
    output logic                 o_cfg_done,
    output logic                 o_cfg_err,
    output logic                 o_div_clk,
    output logic                 o_tick,
    output logic                 o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(2);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] pdiv_q, pdiv_d;
    logic                 pend_q, pend_d;
    logic                 pos_q, pos_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 wrap;
    logic                 accept;
    logic                 apply;
    logic [CNT_WIDTH-1:0] half;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pdiv_d   = pdiv_q;
        pend_d   = pend_q;
        pos_d    = pos_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        wrap     = (state_q != ST_IDLE) && (cnt_q == (div_q - CNT_ONE));
        accept   = i_cfg_valid && !pend_q;
        apply    = pend_q && ((state_q == ST_IDLE) || wrap);
        cnt_next = wrap ? '0 : (cnt_q + CNT_ONE);

        // accept requires !pend_q, so accept and apply never coincide
        if (apply) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
            done_d = 1'b1;
        end
        if (accept) begin
            if (i_cfg_div < CNT_TWO) begin
                err_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                pdiv_d = i_cfg_div;
            end
        end

        // high-phase length follows the divisor that governs the upcoming count
        half = div_d >> 1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                pos_d = 1'b0;
                if (i_en) begin
                    state_d = ST_RUN;
                    pos_d   = 1'b1;
                end
            end
            ST_RUN, ST_STOP: begin
                if ((state_q == ST_STOP) && !i_en && wrap) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pos_d   = 1'b0;
                end else begin
                    state_d = i_en ? ST_RUN : ST_STOP;
                    cnt_d   = cnt_next;
                    pos_d   = (cnt_next < half);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pos_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            pdiv_q  <= DIV_RST;
            pend_q  <= 1'b0;
            pos_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pend_q  <= pend_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef CLK_DIV_ODD_DUTY_EN
    logic neg_q, neg_d;

    // half-cycle extension of the high phase, only for odd divisors
    always_comb begin
        neg_d = pos_q && div_q[0] && (state_q != ST_IDLE);
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign o_div_clk = pos_q | neg_q;
`else
    assign o_div_clk = pos_q;
`endif

    assign o_cfg_ready = !pend_q;
    assign o_cfg_done  = done_q;
    assign o_cfg_err   = err_q;
    assign o_tick      = (state_q != ST_IDLE) && (cnt_q == (div_q - CNT_ONE));
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: table of divisor updates, scoreboard of config
// pulses, plus hand-written start/stop and async-reset sequences.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    localparam int W = 8;
`ifdef CLK_DIV_ODD_DUTY_EN
    localparam int ODD_X = 1;
`else
    localparam int ODD_X = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready, cfg_done, cfg_err, div_clk, tick, busy;

    int total = 0;
    int bad   = 0;
    int cur_div = 12;

    // scoreboard codes: 2'b10 = done pulse, 2'b01 = err pulse
    logic [1:0] sb[$];

    typedef struct {
        int div;
        int hi;
        int lo;
        bit err;
    } vec_t;
    vec_t vecs[9];

    clk_div_ctrl #(.CNT_WIDTH(W), .DEFAULT_DIV(12)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .i_cfg_div   (cfg_div),
        .o_cfg_ready (cfg_ready),
        .o_cfg_done  (cfg_done),
        .o_cfg_err   (cfg_err),
        .o_div_clk   (div_clk),
        .o_tick      (tick),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench at the sample of the first cycle of a period (counter = 0)
    task automatic sync_period_start();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        check("tick_seen", {31'd0, tick}, 1);
        step();
    endtask

    task automatic measure(input string name, input int exp_hi, input int exp_lo);
        int   hi;
        int   lo;
        logic last_tick;
        hi = 0;
        lo = 0;
        last_tick = 1'b0;
        while (div_clk === 1'b1 && hi < 400) begin
            hi++;
            step();
        end
        while (div_clk === 1'b0 && lo < 400) begin
            last_tick = tick;
            lo++;
            step();
        end
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_tick"}, {31'd0, last_tick}, 1);
    endtask

    task automatic run_pattern(input string name, input int cycles, input int drop_at, input int raise_at);
        for (int k = 0; k < cycles; k++) begin
            check({name, "_clk"}, {31'd0, div_clk}, ((k % 12) < 6) ? 1 : 0);
            check({name, "_tick"}, {31'd0, tick}, ((k % 12) == 11) ? 1 : 0);
            check({name, "_busy"}, {31'd0, busy}, 1);
            if (k == drop_at) en = 1'b0;
            if (k == raise_at) en = 1'b1;
            step();
        end
    endtask

    // pulse monitor: every done/err pulse must match the oldest expected entry
    always @(posedge clk) begin
        logic [1:0] exp;
        #2;
        if (cfg_done || cfg_err) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {30'd0, cfg_done, cfg_err}, 0);
            end else begin
                exp = sb.pop_front();
                check("sb_pulse", {30'd0, cfg_done, cfg_err}, {30'd0, exp});
            end
        end
    end

    initial begin
        vecs[0] = '{div: 1,   hi: 6,           lo: 6,           err: 1'b1};
        vecs[1] = '{div: 0,   hi: 6,           lo: 6,           err: 1'b1};
        vecs[2] = '{div: 4,   hi: 2,           lo: 2,           err: 1'b0};
        vecs[3] = '{div: 5,   hi: 2 + ODD_X,   lo: 3 - ODD_X,   err: 1'b0};
        vecs[4] = '{div: 6,   hi: 3,           lo: 3,           err: 1'b0};
        vecs[5] = '{div: 2,   hi: 1,           lo: 1,           err: 1'b0};
        vecs[6] = '{div: 255, hi: 127 + ODD_X, lo: 128 - ODD_X, err: 1'b0};
        vecs[7] = '{div: 3,   hi: 1 + ODD_X,   lo: 2 - ODD_X,   err: 1'b0};
        vecs[8] = '{div: 12,  hi: 6,           lo: 6,           err: 1'b0};

        // reset state
        #3;
        check("rst_div_clk", {31'd0, div_clk}, 0);
        check("rst_tick", {31'd0, tick}, 0);
        check("rst_done", {31'd0, cfg_done}, 0);
        check("rst_err", {31'd0, cfg_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ready", {31'd0, cfg_ready}, 1);

        // default divisor 12 after release
        step();
        step();
        rst_n = 1'b1;
        en = 1'b1;
        step();
        run_pattern("run12", 36, -1, -1);

        // divisor updates, mid-period where the old divisor allows it
        for (int i = 0; i < 9; i++) begin
            int off;
            int lat;
            int exp_lat;
            sync_period_start();
            off = (cur_div > 3) ? 2 : 0;
            repeat (off) step();
            cfg_valid = 1'b1;
            cfg_div = W'(vecs[i].div);
            sb.push_back(vecs[i].err ? 2'b01 : 2'b10);
            step();
            cfg_valid = 1'b0;
            lat = 1;
            check("ready_after_accept", {31'd0, cfg_ready}, {31'd0, vecs[i].err});
            while (!(cfg_done || cfg_err) && lat < 600) begin
                step();
                lat++;
            end
            exp_lat = vecs[i].err ? 1 : (cur_div - off);
            check("cfg_latency", lat, exp_lat);
            if (!vecs[i].err) begin
                check("apply_start_clk", {31'd0, div_clk}, 1);
                check("ready_after_apply", {31'd0, cfg_ready}, 1);
                step();
                check("done_width", {31'd0, cfg_done}, 0);
                measure("new_period", vecs[i].hi - 1, vecs[i].lo);
                cur_div = vecs[i].div;
            end else begin
                sync_period_start();
                measure("kept_period", vecs[i].hi, vecs[i].lo);
            end
        end

        // stop at counter 2: period finishes, then idle
        sync_period_start();
        step();
        step();
        en = 1'b0;
        for (int k = 3; k < 12; k++) begin
            step();
            check("stop_clk", {31'd0, div_clk}, (k < 6) ? 1 : 0);
            check("stop_tick", {31'd0, tick}, (k == 11) ? 1 : 0);
            check("stop_busy", {31'd0, busy}, 1);
        end
        step();
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_clk", {31'd0, div_clk}, 0);
        check("idle_tick", {31'd0, tick}, 0);
        repeat (5) step();
        check("idle_hold_clk", {31'd0, div_clk}, 0);
        check("idle_hold_busy", {31'd0, busy}, 0);

        // restart, then drop and re-raise enable within a period: no gap
        en = 1'b1;
        step();
        run_pattern("restop", 36, 2, 5);

        // async reset mid-high-phase with an update pending
        step();
        cfg_valid = 1'b1;
        cfg_div = W'(4);
        step();
        cfg_valid = 1'b0;
        check("pend_ready", {31'd0, cfg_ready}, 0);
        check("pend_clk", {31'd0, div_clk}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk", {31'd0, div_clk}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_ready", {31'd0, cfg_ready}, 1);
        check("arst_tick", {31'd0, tick}, 0);
        en = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_ready", {31'd0, cfg_ready}, 1);
        check("post_rst_busy", {31'd0, busy}, 0);
        en = 1'b1;
        step();
        run_pattern("post_rst", 24, -1, -1);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
